// File: rtl/pwm_tone_divider.sv
// Glitch-free tone/heartbeat divider: square or single-pulse output at BASE_FREQ/period,
// with new settings applied only at output-period boundaries.
module pwm_tone_divider #(
    parameter int CLK_FREQ  = 12_000_000,
    parameter int BASE_FREQ = 2400,
    parameter int PERIOD_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [PERIOD_W-1:0] period,
    input  logic                pulse_mode,
    output logic                clk_out,
    output logic                tick,
    output logic [PERIOD_W-1:0] cur_period
);

    localparam int HALF_UNIT = CLK_FREQ / (2 * BASE_FREQ);
    localparam int PRE_W     = (HALF_UNIT < 2) ? 1 : $clog2(HALF_UNIT);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(HALF_UNIT - 1);

    generate
        if (HALF_UNIT < 2) begin : g_bad_half_unit
            $error("pwm_tone_divider: CLK_FREQ/(2*BASE_FREQ) must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [PERIOD_W-1:0] hcnt_q, hcnt_d;
    logic [PERIOD_W-1:0] cur_period_q, cur_period_d;
    logic                mode_q, mode_d;
    logic                clk_out_q, clk_out_d;
    logic                tick_q, tick_d;
    logic                half_tick_s;
    logic                phase_end_s;
    logic                start_ok_s;

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            pre_cnt_q    <= '0;
            hcnt_q       <= '0;
            cur_period_q <= '0;
            mode_q       <= 1'b0;
            clk_out_q    <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_cnt_q    <= pre_cnt_d;
            hcnt_q       <= hcnt_d;
            cur_period_q <= cur_period_d;
            mode_q       <= mode_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
        end
    end

    // Prescaler, half-period counter and phase sequencing.
    always_comb begin
        state_d      = state_q;
        cur_period_d = cur_period_q;
        mode_d       = mode_q;
        clk_out_d    = 1'b0;
        tick_d       = 1'b0;
        start_ok_s   = en && (period != '0);
        half_tick_s  = (state_q != ST_IDLE) && (pre_cnt_q == PRE_LAST);
        phase_end_s  = half_tick_s && (hcnt_q == (cur_period_q - PERIOD_W'(1)));

        if (state_q == ST_IDLE || half_tick_s) begin
            pre_cnt_d = '0;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end

        if (state_q == ST_IDLE || phase_end_s) begin
            hcnt_d = '0;
        end else if (half_tick_s) begin
            hcnt_d = hcnt_q + PERIOD_W'(1);
        end else begin
            hcnt_d = hcnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d      = ST_HIGH;
                    cur_period_d = period;
                    mode_d       = pulse_mode;
                    tick_d       = 1'b1;
                    clk_out_d    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH: begin
                if (phase_end_s) begin
                    state_d   = ST_LOW;
                    clk_out_d = 1'b0;
                end else begin
                    // Pulse mode keeps only the entry cycle high.
                    clk_out_d = ~mode_q;
                end
            end
            ST_LOW: begin
                if (phase_end_s) begin
                    if (start_ok_s) begin
                        state_d      = ST_HIGH;
                        cur_period_d = period;
                        mode_d       = pulse_mode;
                        tick_d       = 1'b1;
                        clk_out_d    = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_LOW;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign clk_out    = clk_out_q;
    assign tick       = tick_q;
    assign cur_period = cur_period_q;

endmodule

// File: tb/tb_pwm_tone_divider.sv
// Self-checking bench for pwm_tone_divider: directed vector table, hand-written corner
// sequences and random stimulus, all checked every cycle against a period-position model.
module tb_pwm_tone_divider;

    localparam int HU = 3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] period;
    logic       pulse_mode;
    logic       clk_out;
    logic       tick;
    logic [3:0] cur_period;

    int n_checks;
    int n_fail;

    // Model: whether a period is running, position within it, and the latched settings.
    bit         m_run;
    int         m_pos;
    logic [3:0] m_cur;
    logic       m_mode;

    typedef struct {
        logic       en;
        logic [3:0] period;
        logic       pm;
        int         ncyc;
        logic       exp_clk;
        logic       exp_tick;
        logic [3:0] exp_cur;
    } vec_t;

    vec_t vecs[11];

    pwm_tone_divider #(
        .CLK_FREQ (12),
        .BASE_FREQ(2),
        .PERIOD_W (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .period    (period),
        .pulse_mode(pulse_mode),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_period(cur_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        if (m_run) begin
            m_pos++;
            if (m_pos == 2 * int'(m_cur) * HU) begin
                if (en && period != 4'd0) begin
                    m_cur  = period;
                    m_mode = pulse_mode;
                    m_pos  = 0;
                end else begin
                    m_run = 1'b0;
                end
            end
        end else if (en && period != 4'd0) begin
            m_run  = 1'b1;
            m_cur  = period;
            m_mode = pulse_mode;
            m_pos  = 0;
        end
    endtask

    task automatic check_model();
        logic exp_clk;
        logic exp_tick;
        exp_tick = m_run && (m_pos == 0);
        if (!m_run)      exp_clk = 1'b0;
        else if (m_mode) exp_clk = (m_pos == 0);
        else             exp_clk = (m_pos < int'(m_cur) * HU);
        check("model_clk_out", {31'd0, clk_out}, {31'd0, exp_clk});
        check("model_tick", {31'd0, tick}, {31'd0, exp_tick});
        check("model_cur_period", {28'd0, cur_period}, {28'd0, m_cur});
    endtask

    // Called at a falling edge: apply inputs, step across one rising edge, check at the next falling edge.
    task automatic drive_cycle(input logic e, input logic [3:0] p, input logic m);
        en         = e;
        period     = p;
        pulse_mode = m;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        int hi_cnt;
        int guard;
        logic e_r;
        logic [3:0] p_r;
        logic m_r;

        n_checks   = 0;
        n_fail     = 0;
        m_run      = 1'b0;
        m_pos      = 0;
        m_cur      = 4'd0;
        m_mode     = 1'b0;
        rst_n      = 1'b0;
        en         = 1'b0;
        period     = 4'd0;
        pulse_mode = 1'b0;

        vecs[0]  = '{1'b0, 4'd2, 1'b0,  3, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 4'd2, 1'b0,  1, 1'b1, 1'b1, 4'd2};
        vecs[2]  = '{1'b1, 4'd2, 1'b0,  5, 1'b1, 1'b0, 4'd2};
        vecs[3]  = '{1'b1, 4'd2, 1'b0,  1, 1'b0, 1'b0, 4'd2};
        vecs[4]  = '{1'b1, 4'd2, 1'b0,  6, 1'b1, 1'b1, 4'd2};
        vecs[5]  = '{1'b1, 4'd0, 1'b0, 11, 1'b0, 1'b0, 4'd2};
        vecs[6]  = '{1'b1, 4'd0, 1'b0,  1, 1'b0, 1'b0, 4'd2};
        vecs[7]  = '{1'b1, 4'd3, 1'b1,  1, 1'b1, 1'b1, 4'd3};
        vecs[8]  = '{1'b1, 4'd3, 1'b1,  1, 1'b0, 1'b0, 4'd3};
        vecs[9]  = '{1'b0, 4'd3, 1'b1, 16, 1'b0, 1'b0, 4'd3};
        vecs[10] = '{1'b0, 4'd3, 1'b1,  1, 1'b0, 1'b0, 4'd3};

        #1;
        check("reset_clk_out", {31'd0, clk_out}, 32'd0);
        check("reset_tick", {31'd0, tick}, 32'd0);
        check("reset_cur_period", {28'd0, cur_period}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < vecs[i].ncyc; c++) begin
                drive_cycle(vecs[i].en, vecs[i].period, vecs[i].pm);
            end
            check($sformatf("vec%0d_clk_out", i), {31'd0, clk_out}, {31'd0, vecs[i].exp_clk});
            check($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, vecs[i].exp_tick});
            check($sformatf("vec%0d_cur_period", i), {28'd0, cur_period}, {28'd0, vecs[i].exp_cur});
        end

        // Period 1 -> 3 requested mid-HIGH: current 6-cycle period completes untouched.
        drive_cycle(1'b1, 4'd1, 1'b0);
        drive_cycle(1'b1, 4'd1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            drive_cycle(1'b1, 4'd3, 1'b0);
            check("midperiod_cur_period_held", {28'd0, cur_period}, 32'd1);
        end
        drive_cycle(1'b1, 4'd3, 1'b0);
        check("boundary_cur_period", {28'd0, cur_period}, 32'd3);
        check("boundary_tick", {31'd0, tick}, 32'd1);
        hi_cnt = int'(clk_out);
        for (int c = 0; c < 17; c++) begin
            drive_cycle(1'b1, 4'd3, 1'b0);
            hi_cnt += int'(clk_out);
        end
        check("period3_high_cycles", hi_cnt, 32'd9);

        // Pulse mode requested mid-period only applies at the next boundary.
        drive_cycle(1'b1, 4'd3, 1'b1);
        check("pm_switch_boundary_tick", {31'd0, tick}, 32'd1);
        for (int c = 0; c < 17; c++) drive_cycle(1'b1, 4'd3, 1'b1);
        drive_cycle(1'b1, 4'd3, 1'b1);
        drive_cycle(1'b1, 4'd3, 1'b1);
        check("pulse_mode_second_cycle_low", {31'd0, clk_out}, 32'd0);

        // Maximum period runs through two full periods without overflow.
        for (int c = 0; c < 2 * 15 * HU * 2 + 4; c++) drive_cycle(1'b1, 4'd15, 1'b0);
        guard = 0;
        while (m_run && guard < 200) begin
            drive_cycle(1'b0, 4'd15, 1'b0);
            guard++;
        end
        check("drain_to_idle_in_budget", {31'd0, m_run}, 32'd0);

        // Asynchronous reset mid-HIGH, then restart at period 1.
        drive_cycle(1'b1, 4'd1, 1'b0);
        drive_cycle(1'b1, 4'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_clk_out", {31'd0, clk_out}, 32'd0);
        check("async_rst_tick", {31'd0, tick}, 32'd0);
        check("async_rst_cur_period", {28'd0, cur_period}, 32'd0);
        m_run = 1'b0;
        m_pos = 0;
        m_cur = 4'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 4'd1, 1'b0);
        check("post_reset_first_rise", {31'd0, clk_out}, 32'd1);
        for (int c = 0; c < 12; c++) drive_cycle(1'b1, 4'd1, 1'b0);

        // Random settings, changed occasionally, against the model.
        e_r = 1'b1;
        p_r = 4'd2;
        m_r = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 15) == 0) e_r = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 15) == 0) p_r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) m_r = 1'($urandom_range(0, 1));
            drive_cycle(e_r, p_r, m_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
